datapath: RTL and testbench
===========================

# datapath

Execution half of the processor: consumes the control word that the controller's state machine issues each cycle and performs the register-file, ALU and data-memory work it names. Holds a 16×16 register file, a 256×16 synchronous data memory and a combinational ALU. Writeback is selected between memory read data and ALU result. Results are exposed for board display and bench checking.

## Interface
- DATA_W, 16, datapath word width
- D_ADDR_W, 8, data-memory address width (depth 2^D_ADDR_W)
- RF_ADDR_W, 4, register-file address width (16 registers)

- Clock  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-high reset
- D_addr  in  8  data-memory address
- D_wr  in  1  data-memory write enable
- RF_s  in  1  writeback select: 1 = memory read data, 0 = ALU result
- RF_W_addr  in  4  register-file write address
- RF_W_en  in  1  register-file write enable
- RF_Ra_addr  in  4  read port A address
- RF_Rb_addr  in  4  read port B address
- ALU_s0  in  3  ALU operation select
- Ra_data  out  16  RF[RF_Ra_addr], combinational
- Rb_data  out  16  RF[RF_Rb_addr], combinational
- R_data  out  16  registered data-memory read data
- W_data  out  16  writeback value presented to the register file
- ALU_out  out  16  ALU result, combinational

## Operation
- **Register file:**
  - 16 registers, asynchronously cleared to 0 by Reset.
  - Write W_data into RF[RF_W_addr] on a rising edge when RF_W_en=1.
  - Two combinational read ports with no write-to-read bypass.
- **Data memory:**
  - On each rising edge, R_data <= mem[D_addr], regardless of D_wr. This gives one cycle of read latency.
  - When D_wr=1, mem[D_addr] <= Ra_data on the same edge.
  - Contents are not reset.
  - R_data register is asynchronously cleared to 0.
- **ALU (A=Ra_data, B=Rb_data), all results mod 2^16, no flags:**
  - 000 → 0
  - 001 → A+B
  - 010 → A−B
  - 011 → A
  - 100 → A^B
  - 101 → A|B
  - 110 → A&B
  - 111 → A+1
- **Writeback:** W_data = RF_s ? R_data : ALU_out.
- **Instruction mapping:**
  - STORE is one cycle with D_wr=1.
  - LOAD is two cycles: first D_addr is presented, then D_addr is held with RF_s=1 and RF_W_en=1.
  - ALU ops are one cycle with RF_s=0 and RF_W_en=1.

## Timing
- **Reset values:**
  - Every RF entry is 0 and R_data is 0.
  - Consequently Ra_data, Rb_data, ALU_out (op 000/011) and W_data read as 0.
  - ALU_out for op 111 reads 1.
- **Reset mid-operation:** Reset wins over any write on the same edge. No RF or memory update occurs while Reset=1.
- **Latency:**
  - Ra/Rb/ALU_out/W_data: 0 cycles (combinational).
  - R_data: 1 cycle after D_addr.
  - RF write is visible on the read ports the cycle after the edge.
- **Memory, D_wr=1 with the same D_addr:** R_data captures the old contents (read-before-write). The new value appears on the next edge.
- **RF, RF_W_en=1 with RF_Ra_addr==RF_W_addr:** Ra_data shows the old value until the edge.
- **Self-referencing ALU writes:** A write whose operands read the destination (e.g. R3 <= R3+R3) uses pre-edge values and is well defined.
- **Address/value wrap:**
  - D_addr is the full 8-bit range with no wrap logic.
  - 0xFFFF+1 = 0x0000.
  - 0x0000−1 = 0xFFFF.
- **Undefined ALU_s0:** none; all 8 codes are defined.

## Structure
- Shared package processor_pkg holds:
  - ALU op localparams: ALU_ZERO, ALU_ADD, ALU_SUB, ALU_PASSA, ALU_XOR, ALU_OR, ALU_AND, ALU_INC.
  - DATA_W, D_ADDR_W and RF_ADDR_W defaults.
- The controller's state machine imports the same package.
- One sub-module, regfile (16×16, 1W/2R, async clear), instantiated once.
- ALU, data memory and writeback mux stay inline in datapath.
- Data memory is written as an inferable synchronous RAM with no reset on the array.

## Test plan
- Reset asserted mid-cycle with RF_W_en=1 → all RF reads 0 and R_data=0 immediately; no write lands; release → still 0.
- Write R1=0x0005 (ALU path via RF_s=0, op 111 from R0 twice), R2=0x0003, then ALU_s0=001/010 with Ra=1, Rb=2 → ALU_out 0x0008, then 0x0002; R1−R2 with swapped operands → 0xFFFE.
- STORE R1 to D_addr 0x80 (D_wr=1), next cycle present 0x80 → R_data=0x0005 one edge later, not same cycle.
- Same-edge D_wr=1 at 0x10 (old 0x0000, Ra_data 0x1234) → R_data=0x0000 after that edge, 0x1234 after the next.
- LOAD sequence D_addr=0x80, then RF_s=1, RF_W_en=1, RF_W_addr=7 → R7=0x0005; Ra_addr=7 during the write cycle reads old 0x0000.
- Sweep all 8 ALU_s0 codes with A=0xFFFF, B=0x00F0 → 0x0000, 0x00EF, 0xFF0F, 0xFFFF, 0xFF0F, 0xFFFF, 0x00F0, 0x0000.

Source files
------------

// File: rtl/processor_pkg.sv
// processor_pkg: definitions shared by the processor's datapath and its
// controller state machine.
//   DATA_W    : datapath word width
//   D_ADDR_W  : data-memory address width (depth 2**D_ADDR_W)
//   RF_ADDR_W : register-file address width
//   ALU_*     : ALU operation codes carried on ALU_s0
package processor_pkg;

  localparam int DATA_W    = 16;
  localparam int D_ADDR_W  = 8;
  localparam int RF_ADDR_W = 4;

  localparam logic [2:0] ALU_ZERO  = 3'b000;
  localparam logic [2:0] ALU_ADD   = 3'b001;
  localparam logic [2:0] ALU_SUB   = 3'b010;
  localparam logic [2:0] ALU_PASSA = 3'b011;
  localparam logic [2:0] ALU_XOR   = 3'b100;
  localparam logic [2:0] ALU_OR    = 3'b101;
  localparam logic [2:0] ALU_AND   = 3'b110;
  localparam logic [2:0] ALU_INC   = 3'b111;

endpackage

// File: rtl/datapath_regfile.sv
// regfile: 16 x 16 register file, one write port and two combinational
// read ports, asynchronously cleared.
//   clk_i       : rising-edge clock
//   rst_i       : asynchronous active-high clear of every register
//   we_i        : write enable
//   waddr_i     : write address
//   wdata_i     : write data
//   raddr_a_i   : read port A address
//   raddr_b_i   : read port B address
//   rdata_a_o   : contents of regs[raddr_a_i]
//   rdata_b_o   : contents of regs[raddr_b_i]
// Reads return the pre-edge contents: a write is only visible after the
// edge that performs it (no write-to-read bypass).
module regfile
  import processor_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 we_i,
  input  logic [RF_ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0]    wdata_i,
  input  logic [RF_ADDR_W-1:0] raddr_a_i,
  input  logic [RF_ADDR_W-1:0] raddr_b_i,
  output logic [DATA_W-1:0]    rdata_a_o,
  output logic [DATA_W-1:0]    rdata_b_o
);

  localparam int NREGS = 2 ** RF_ADDR_W;

  logic [DATA_W-1:0] regs_q [NREGS];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = regs_q[raddr_a_i];
  assign rdata_b_o = regs_q[raddr_b_i];

endmodule

// File: rtl/datapath.sv
// datapath: execution half of the processor. Performs the register-file,
// ALU and data-memory work named by the controller's control word.
//   Clock      : rising-edge clock
//   Reset      : asynchronous active-high reset (RF and R_data only)
//   D_addr     : data-memory address
//   D_wr       : data-memory write enable (writes Ra_data)
//   RF_s       : writeback select, 1 = memory read data, 0 = ALU result
//   RF_W_addr  : register-file write address
//   RF_W_en    : register-file write enable
//   RF_Ra_addr : read port A address
//   RF_Rb_addr : read port B address
//   ALU_s0     : ALU operation select (see processor_pkg ALU_*)
//   Ra_data    : RF[RF_Ra_addr], combinational
//   Rb_data    : RF[RF_Rb_addr], combinational
//   R_data     : registered data-memory read data (one cycle latency)
//   W_data     : writeback value presented to the register file
//   ALU_out    : ALU result, combinational
module datapath
  import processor_pkg::*;
(
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic [D_ADDR_W-1:0]  D_addr,
  input  logic                 D_wr,
  input  logic                 RF_s,
  input  logic [RF_ADDR_W-1:0] RF_W_addr,
  input  logic                 RF_W_en,
  input  logic [RF_ADDR_W-1:0] RF_Ra_addr,
  input  logic [RF_ADDR_W-1:0] RF_Rb_addr,
  input  logic [2:0]           ALU_s0,
  output logic [DATA_W-1:0]    Ra_data,
  output logic [DATA_W-1:0]    Rb_data,
  output logic [DATA_W-1:0]    R_data,
  output logic [DATA_W-1:0]    W_data,
  output logic [DATA_W-1:0]    ALU_out
);

  localparam int D_DEPTH = 2 ** D_ADDR_W;

  logic [DATA_W-1:0] mem_q [D_DEPTH];
  logic [DATA_W-1:0] r_data_q;
  logic [DATA_W-1:0] r_data_d;
  logic [DATA_W-1:0] alu_d;

  regfile u_regfile (
    .clk_i     (Clock),
    .rst_i     (Reset),
    .we_i      (RF_W_en),
    .waddr_i   (RF_W_addr),
    .wdata_i   (W_data),
    .raddr_a_i (RF_Ra_addr),
    .raddr_b_i (RF_Rb_addr),
    .rdata_a_o (Ra_data),
    .rdata_b_o (Rb_data)
  );

  // Data memory array: no reset so it maps onto a synchronous RAM. The
  // write is gated while Reset is high so a reset edge never lands a store.
  always_ff @(posedge Clock) begin
    if (D_wr && !Reset) begin
      mem_q[D_addr] <= Ra_data;
    end
  end

  // Read-before-write: the read register samples the pre-edge contents,
  // so a store to the same address shows up one edge later.
  assign r_data_d = mem_q[D_addr];

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_data_q <= '0;
    end else begin
      r_data_q <= r_data_d;
    end
  end

  assign R_data = r_data_q;

  always_comb begin
    alu_d = '0;
    case (ALU_s0)
      ALU_ZERO:  alu_d = '0;
      ALU_ADD:   alu_d = Ra_data + Rb_data;
      ALU_SUB:   alu_d = Ra_data - Rb_data;
      ALU_PASSA: alu_d = Ra_data;
      ALU_XOR:   alu_d = Ra_data ^ Rb_data;
      ALU_OR:    alu_d = Ra_data | Rb_data;
      ALU_AND:   alu_d = Ra_data & Rb_data;
      ALU_INC:   alu_d = Ra_data + 16'd1;
      default:   alu_d = '0;
    endcase
  end

  assign ALU_out = alu_d;
  assign W_data  = RF_s ? R_data : ALU_out;

endmodule

// File: tb/tb_datapath.sv
module tb_datapath;
  import processor_pkg::*;

  localparam int W = 5 * 16;

  logic        Clock;
  logic        Reset;
  logic [7:0]  D_addr;
  logic        D_wr;
  logic        RF_s;
  logic [3:0]  RF_W_addr;
  logic        RF_W_en;
  logic [3:0]  RF_Ra_addr;
  logic [3:0]  RF_Rb_addr;
  logic [2:0]  ALU_s0;
  logic [15:0] Ra_data;
  logic [15:0] Rb_data;
  logic [15:0] R_data;
  logic [15:0] W_data;
  logic [15:0] ALU_out;

  datapath dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .D_addr     (D_addr),
    .D_wr       (D_wr),
    .RF_s       (RF_s),
    .RF_W_addr  (RF_W_addr),
    .RF_W_en    (RF_W_en),
    .RF_Ra_addr (RF_Ra_addr),
    .RF_Rb_addr (RF_Rb_addr),
    .ALU_s0     (ALU_s0),
    .Ra_data    (Ra_data),
    .Rb_data    (Rb_data),
    .R_data     (R_data),
    .W_data     (W_data),
    .ALU_out    (ALU_out)
  );

  // ---------------- clock / reset ----------------
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // ---------------- reference model ----------------
  logic [15:0] rf_m [16];
  logic [15:0] mem_m [256];
  logic [15:0] r_data_m;

  function automatic logic [15:0] ref_alu(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    int unsigned ai, bi, r;
    ai = a;
    bi = b;
    case (op)
      3'd0: r = 0;
      3'd1: r = (ai + bi) % 65536;
      3'd2: r = (ai + 65536 - bi) % 65536;
      3'd3: r = ai;
      3'd4: r = ai ^ bi;
      3'd5: r = ai | bi;
      3'd6: r = ai & bi;
      default: r = (ai + 1) % 65536;
    endcase
    return r[15:0];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) rf_m[i] = 16'h0000;
    r_data_m = 16'h0000;
  endtask

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every cycle with a pending expectation, compare the outputs
  // at the falling edge, well away from the active edge.
  logic [W-1:0] e;
  always @(negedge Clock) begin
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("Ra_data", Ra_data, e[79:64]);
      chk("Rb_data", Rb_data, e[63:48]);
      chk("R_data",  R_data,  e[47:32]);
      chk("W_data",  W_data,  e[31:16]);
      chk("ALU_out", ALU_out, e[15:0]);
    end
  end

  // ---------------- driver ----------------
  // Drives one control word, records the expected pre-edge outputs, then
  // advances the model to its post-edge state.
  task automatic step(input logic [7:0] addr, input logic dwr, input logic rfs,
                      input logic [3:0] wa, input logic wen,
                      input logic [3:0] ra, input logic [3:0] rb, input logic [2:0] op);
    logic [15:0] a, b, alu, w;
    D_addr = addr; D_wr = dwr; RF_s = rfs; RF_W_addr = wa; RF_W_en = wen;
    RF_Ra_addr = ra; RF_Rb_addr = rb; ALU_s0 = op;
    a = rf_m[ra];
    b = rf_m[rb];
    alu = ref_alu(op, a, b);
    w = rfs ? r_data_m : alu;
    exp_q.push_back({a, b, r_data_m, w, alu});
    if (!Reset) begin
      if (wen) rf_m[wa] = w;
      r_data_m = mem_m[addr];
      if (dwr) mem_m[addr] = a;
    end
    @(posedge Clock);
    #1;
  endtask

  // Build an arbitrary constant in register r using only ALU ops:
  // clear, then shift-left by self-add and increment per set bit.
  task automatic load_const(input logic [3:0] r, input logic [15:0] val);
    step(8'h00, 1'b0, 1'b0, r, 1'b1, r, r, ALU_ZERO);
    for (int i = 15; i >= 0; i--) begin
      step(8'h00, 1'b0, 1'b0, r, 1'b1, r, r, ALU_ADD);
      if (val[i]) step(8'h00, 1'b0, 1'b0, r, 1'b1, r, r, ALU_INC);
    end
  endtask

  // Reset raised between edges while a register and memory write are
  // requested; held across one edge, then released.
  task automatic reset_mid();
    logic [3:0] ra;
    ra = 4'($urandom_range(0, 15));
    RF_W_en = 1'b1;
    D_wr = 1'b1;
    #2;
    Reset = 1'b1;
    model_reset();
    step(8'($urandom_range(0, 255)), 1'b1, 1'b0, ra, 1'b1, ra, ra, ALU_PASSA);
    Reset = 1'b0;
    step(8'h00, 1'b0, 1'b0, 4'd0, 1'b0, ra, 4'($urandom_range(0, 15)), ALU_INC);
  endtask

  initial begin
    Reset = 1'b1;
    D_addr = '0; D_wr = 1'b0; RF_s = 1'b0; RF_W_addr = '0; RF_W_en = 1'b0;
    RF_Ra_addr = '0; RF_Rb_addr = '0; ALU_s0 = '0;
    model_reset();
    for (int i = 0; i < 256; i++) mem_m[i] = 16'h0000;
    repeat (2) @(posedge Clock);
    #1;
    // Reset state, including op 111 reading 1.
    step(8'h00, 1'b0, 1'b0, 4'd3, 1'b1, 4'd3, 4'd4, ALU_INC);
    step(8'h00, 1'b0, 1'b0, 4'd3, 1'b1, 4'd3, 4'd4, ALU_PASSA);
    Reset = 1'b0;

    // Memory contents are not reset: clear every location through R0.
    for (int i = 0; i < 256; i++) step(8'(i), 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, ALU_ZERO);

    // R1 = 5, R2 = 3 via increments, then add / sub / swapped sub.
    step(8'h00, 1'b0, 1'b0, 4'd1, 1'b1, 4'd0, 4'd0, ALU_INC);
    repeat (4) step(8'h00, 1'b0, 1'b0, 4'd1, 1'b1, 4'd1, 4'd1, ALU_INC);
    step(8'h00, 1'b0, 1'b0, 4'd2, 1'b1, 4'd0, 4'd0, ALU_INC);
    repeat (2) step(8'h00, 1'b0, 1'b0, 4'd2, 1'b1, 4'd2, 4'd2, ALU_INC);
    step(8'h00, 1'b0, 1'b0, 4'd0, 1'b0, 4'd1, 4'd2, ALU_ADD);
    step(8'h00, 1'b0, 1'b0, 4'd0, 1'b0, 4'd1, 4'd2, ALU_SUB);
    step(8'h00, 1'b0, 1'b0, 4'd0, 1'b0, 4'd2, 4'd1, ALU_SUB);

    // STORE R1 to 0x80, then read back with one cycle of latency.
    step(8'h80, 1'b1, 1'b0, 4'd0, 1'b0, 4'd1, 4'd0, ALU_ZERO);
    step(8'h80, 1'b0, 1'b0, 4'd0, 1'b0, 4'd1, 4'd0, ALU_ZERO);
    step(8'h00, 1'b0, 1'b0, 4'd0, 1'b0, 4'd1, 4'd0, ALU_ZERO);

    // Read-before-write at 0x10 with Ra_data = 0x1234.
    load_const(4'd3, 16'h1234);
    step(8'h10, 1'b1, 1'b0, 4'd0, 1'b0, 4'd3, 4'd0, ALU_PASSA);
    step(8'h10, 1'b0, 1'b0, 4'd0, 1'b0, 4'd3, 4'd0, ALU_PASSA);
    step(8'h10, 1'b0, 1'b0, 4'd0, 1'b0, 4'd3, 4'd0, ALU_PASSA);

    // LOAD R7 <- mem[0x80]; Ra on R7 sees the old value during the write.
    step(8'h80, 1'b0, 1'b0, 4'd0, 1'b0, 4'd7, 4'd0, ALU_ZERO);
    step(8'h80, 1'b0, 1'b1, 4'd7, 1'b1, 4'd7, 4'd0, ALU_ZERO);
    step(8'h00, 1'b0, 1'b0, 4'd0, 1'b0, 4'd7, 4'd0, ALU_PASSA);

    // All ALU codes with A = 0xFFFF, B = 0x00F0 (covers add/inc wrap).
    load_const(4'd4, 16'hFFFF);
    load_const(4'd5, 16'h00F0);
    for (int op = 0; op < 8; op++) step(8'h00, 1'b0, 1'b0, 4'd0, 1'b0, 4'd4, 4'd5, 3'(op));
    // 0x0000 - 1 wraps to 0xFFFF.
    step(8'h00, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd6, ALU_SUB);
    step(8'h00, 1'b0, 1'b0, 4'd6, 1'b1, 4'd0, 4'd0, ALU_INC);
    step(8'h00, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd6, ALU_SUB);

    reset_mid();

    // Randomised control words.
    for (int n = 0; n < 600; n++) begin
      step(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
           4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)));
      if (n == 300) reset_mid();
    end

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge Clock);
    #1;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain got %0d pending expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
